// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
// The FSM encoding and constant-function helpers live here.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StFill,
    StResp
  } state_e;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned addr_idx(input int unsigned addr, input int unsigned idx_w);
    return addr & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic int unsigned addr_tag(input int unsigned addr, input int unsigned idx_w);
    return addr >> idx_w;
  endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Age-based LRU update for one set: the used way becomes 0 and younger ways age by one.
// Also reports the current least recently used way (age == WAYS-1).
module cache_lru_ages
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned AGE_W = clog2_f(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [AGE_W-1:0]           use_way,
  output logic [WAYS-1:0][AGE_W-1:0] new_ages,
  output logic [AGE_W-1:0]           lru_way
);

  logic [AGE_W-1:0] use_age;

  always_comb begin
    use_age  = ages[use_way];
    lru_way  = '0;
    new_ages = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == use_way) begin
        new_ages[w] = '0;
      end else if (ages[w] < use_age) begin
        new_ages[w] = ages[w] + AGE_W'(1);
      end
      if (ages[w] == AGE_W'(WAYS - 1)) begin
        lru_way = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_wb_assoc.sv
// N-way set-associative write-back cache, one word per line, age-based LRU.
// Read misses fill from memory; write misses install locally without a fill.
module cache_wb_assoc
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SETS   = 4,
  parameter int unsigned WAYS   = 4
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      req_in,
  input  logic                      wren_in,
  input  logic [ADDR_W-1:0]         endereco_in,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      busy_out,
  output logic                      ready_out,
  output logic [DATA_W-1:0]         q_out,
  output logic                      hit_out,
  output logic [clog2_f(WAYS)-1:0]  lru_out,
  output logic                      validade_out,
  output logic                      dirty_out,
  output logic                      mem_req_out,
  output logic                      mem_wren_out,
  output logic [ADDR_W-1:0]         mem_addr_out,
  output logic [DATA_W-1:0]         mem_data_out,
  input  logic [DATA_W-1:0]         mem_q_in,
  input  logic                      mem_ack_in
);

  localparam int unsigned IDX_W = clog2_f(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned AGE_W = clog2_f(WAYS);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              dirty;
    logic [AGE_W-1:0]  age;
  } line_t;

  state_e            state_q;
  line_t             lines_q [SETS][WAYS];
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_wren_q;
  logic [AGE_W-1:0]  victim_q;

  logic [IDX_W-1:0]             idx;
  logic [TAG_W-1:0]             tag;
  logic                         hit;
  logic [AGE_W-1:0]             hit_way;
  logic                         inv_found;
  logic [AGE_W-1:0]             inv_way;
  logic [AGE_W-1:0]             victim;
  logic [AGE_W-1:0]             upd_way;
  logic [WAYS-1:0][AGE_W-1:0]   set_ages;
  logic [WAYS-1:0][AGE_W-1:0]   new_ages;
  logic [AGE_W-1:0]             lru_way;
  line_t                        hit_line;
  line_t                        victim_line;
  logic                         mem_ack;

  assign idx = IDX_W'(addr_idx(32'(req_addr_q), IDX_W));
  assign tag = TAG_W'(addr_tag(32'(req_addr_q), IDX_W));
  // An ack is only meaningful while a memory request is outstanding.
  assign mem_ack = mem_ack_in & mem_req_out;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    set_ages  = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_ages[w] = lines_q[idx][w].age;
      if (lines_q[idx][w].valid && (lines_q[idx][w].tag == tag) && !hit) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!lines_q[idx][w].valid && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
    end
    victim      = inv_found ? inv_way : lru_way;
    upd_way     = (state_q == StLookup) ? (hit ? hit_way : victim) : victim_q;
    hit_line    = lines_q[idx][hit_way];
    victim_line = lines_q[idx][victim];
  end

  cache_lru_ages #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru_ages (
    .ages     (set_ages),
    .use_way  (upd_way),
    .new_ages (new_ages),
    .lru_way  (lru_way)
  );

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_wren_q   <= 1'b0;
      victim_q     <= '0;
      busy_out     <= 1'b0;
      ready_out    <= 1'b0;
      q_out        <= '0;
      hit_out      <= 1'b0;
      lru_out      <= '0;
      validade_out <= 1'b0;
      dirty_out    <= 1'b0;
      mem_req_out  <= 1'b0;
      mem_wren_out <= 1'b0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          lines_q[s][w].tag   <= '0;
          lines_q[s][w].data  <= '0;
          lines_q[s][w].valid <= 1'b0;
          lines_q[s][w].dirty <= 1'b0;
          lines_q[s][w].age   <= AGE_W'(w);
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_in) begin
            req_addr_q <= endereco_in;
            req_data_q <= data_in;
            req_wren_q <= wren_in;
            busy_out   <= 1'b1;
            state_q    <= StLookup;
          end
        end

        StLookup: begin
          if (hit) begin
            if (req_wren_q) begin
              lines_q[idx][hit_way].data  <= req_data_q;
              lines_q[idx][hit_way].dirty <= 1'b1;
            end
            for (int w = 0; w < WAYS; w++) lines_q[idx][w].age <= new_ages[w];
            q_out        <= req_wren_q ? req_data_q : hit_line.data;
            hit_out      <= 1'b1;
            lru_out      <= hit_way;
            validade_out <= 1'b1;
            dirty_out    <= req_wren_q | hit_line.dirty;
            ready_out    <= 1'b1;
            state_q      <= StResp;
          end else begin
            victim_q <= victim;
            if (victim_line.valid && victim_line.dirty) begin
              mem_req_out  <= 1'b1;
              mem_wren_out <= 1'b1;
              mem_addr_out <= {victim_line.tag, idx};
              mem_data_out <= victim_line.data;
              state_q      <= StWriteback;
            end else if (!req_wren_q) begin
              mem_req_out  <= 1'b1;
              mem_wren_out <= 1'b0;
              mem_addr_out <= req_addr_q;
              state_q      <= StFill;
            end else begin
              // Write miss into a clean or empty way: install without fetching.
              lines_q[idx][victim].tag   <= tag;
              lines_q[idx][victim].data  <= req_data_q;
              lines_q[idx][victim].valid <= 1'b1;
              lines_q[idx][victim].dirty <= 1'b1;
              for (int w = 0; w < WAYS; w++) lines_q[idx][w].age <= new_ages[w];
              q_out        <= req_data_q;
              hit_out      <= 1'b0;
              lru_out      <= victim;
              validade_out <= 1'b1;
              dirty_out    <= 1'b1;
              ready_out    <= 1'b1;
              state_q      <= StResp;
            end
          end
        end

        StWriteback: begin
          if (mem_ack) begin
            if (req_wren_q) begin
              // Old contents are now in memory; overwrite with the new dirty word.
              lines_q[idx][victim_q].tag   <= tag;
              lines_q[idx][victim_q].data  <= req_data_q;
              lines_q[idx][victim_q].valid <= 1'b1;
              lines_q[idx][victim_q].dirty <= 1'b1;
              for (int w = 0; w < WAYS; w++) lines_q[idx][w].age <= new_ages[w];
              q_out        <= req_data_q;
              hit_out      <= 1'b0;
              lru_out      <= victim_q;
              validade_out <= 1'b1;
              dirty_out    <= 1'b1;
              ready_out    <= 1'b1;
              mem_req_out  <= 1'b0;
              mem_wren_out <= 1'b0;
              state_q      <= StResp;
            end else begin
              lines_q[idx][victim_q].dirty <= 1'b0;
              mem_wren_out <= 1'b0;
              mem_addr_out <= req_addr_q;
              state_q      <= StFill;
            end
          end
        end

        StFill: begin
          if (mem_ack) begin
            lines_q[idx][victim_q].tag   <= tag;
            lines_q[idx][victim_q].data  <= mem_q_in;
            lines_q[idx][victim_q].valid <= 1'b1;
            lines_q[idx][victim_q].dirty <= 1'b0;
            for (int w = 0; w < WAYS; w++) lines_q[idx][w].age <= new_ages[w];
            q_out        <= mem_q_in;
            hit_out      <= 1'b0;
            lru_out      <= victim_q;
            validade_out <= 1'b1;
            dirty_out    <= 1'b0;
            ready_out    <= 1'b1;
            mem_req_out  <= 1'b0;
            state_q      <= StResp;
          end
        end

        StResp: begin
          ready_out <= 1'b0;
          busy_out  <= 1'b0;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
